// File: rtl/arcade_input_conditioner.sv
// arcade_input_conditioner
//
// Upstream conditioning stage for the raw cabinet inputs. Every raw bit is
// brought into the clk domain through a two-flop synchroniser. It is then
// debounced on the slow sample strobe. Coin insertions are queued and
// replayed as clean, fixed-width low pulses. Game code polling at NMI rate
// therefore sees each coin exactly once.
//
// Optional feature:
//   INPUT_COIN_COUNTER_EN  when defined, coin_total counts accepted coins
//                          (16 bits, wrapping). When undefined, coin_total
//                          is tied to zero and no counter is built.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   tick_en        one-clk sample strobe (about 3 kHz); all debounce,
//                  jam and replay state advances only on this strobe
//   btn_raw        raw buttons, active-low, asynchronous
//   coin_raw       raw coin switch, active-low, asynchronous
//   btn_clean      debounced buttons, active-low
//   coin_out       replayed coin pulse, active-low
//   coin_pending   queued coins not yet replayed (saturates at 3)
//   coin_overflow  sticky flag: a coin was dropped on a full queue
//   coin_jam       coin switch held low for too long
//   coin_total     accepted coin count (optional feature, else 0)

module arcade_input_conditioner #(
  parameter int NUM_INPUTS       = 8,
  parameter int DEBOUNCE_TICKS   = 4,
  parameter int COIN_PULSE_TICKS = 6,
  parameter int COIN_GAP_TICKS   = 6,
  parameter int STUCK_TICKS      = 300
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_en,
  input  logic [NUM_INPUTS-1:0] btn_raw,
  input  logic                  coin_raw,
  output logic [NUM_INPUTS-1:0] btn_clean,
  output logic                  coin_out,
  output logic [1:0]            coin_pending,
  output logic                  coin_overflow,
  output logic                  coin_jam,
  output logic [15:0]           coin_total
);

  // The coin switch rides along as the top bit of the button vector, so it
  // shares one synchroniser and debouncer implementation with the buttons.
  localparam int NB = NUM_INPUTS + 1;
  localparam int COIN_BIT = NUM_INPUTS;

  localparam logic [3:0]  DEB_LAST   = 4'(DEBOUNCE_TICKS - 1);
  localparam logic [11:0] STUCK_LAST = 12'(STUCK_TICKS - 1);
  localparam logic [7:0]  PULSE_LAST = 8'(COIN_PULSE_TICKS - 1);
  localparam logic [7:0]  GAP_LAST   = 8'(COIN_GAP_TICKS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PULSE = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [NB-1:0] raw_all;
  logic [NB-1:0] sync_a;
  logic [NB-1:0] sync_b;
  logic [NB-1:0] clean;
  logic [3:0]    deb_cnt [NB];

  logic          coin_clean;
  logic          coin_fall;
  logic          coin_rise;
  logic          coin_accept;
  logic          replay_take;
  logic [1:0]    pending_dec;
  logic [1:0]    pending_next;
  logic          coin_drop;

  logic [11:0]   jam_cnt;
  logic [1:0]    state;
  logic [7:0]    timer;

  assign raw_all    = {coin_raw, btn_raw};
  assign btn_clean  = clean[NUM_INPUTS-1:0];
  assign coin_clean = clean[COIN_BIT];

  // Synchronisers run on every clk, regardless of tick_en. They reset to the
  // idle (released) level so that reset does not create a phantom press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= '1;
      sync_b <= '1;
    end else begin
      sync_a <= raw_all;
      sync_b <= sync_a;
    end
  end

  // Per-bit debounce. The counter counts consecutive sample ticks on which
  // the synced level disagrees with the accepted level. Any agreeing sample
  // restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      clean <= '1;
      for (int i = 0; i < NB; i++) begin
        deb_cnt[i] <= '0;
      end
    end else if (tick_en) begin
      for (int i = 0; i < NB; i++) begin
        if (sync_b[i] != clean[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            clean[i]   <= sync_b[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 4'd1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // The debounced coin edges are decoded from the same condition that flips
  // the clean level. This lets the accept logic act on the very edge where
  // coin_clean changes, rather than one clk later.
  assign coin_fall = tick_en && coin_clean && !sync_b[COIN_BIT]
                     && (deb_cnt[COIN_BIT] == DEB_LAST);
  assign coin_rise = tick_en && !coin_clean && sync_b[COIN_BIT]
                     && (deb_cnt[COIN_BIT] == DEB_LAST);

  // Jam detector. The counter counts sample ticks spent with the debounced
  // coin low and stops once the jam is declared. Releasing the switch
  // clears both the flag and the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      jam_cnt  <= '0;
      coin_jam <= 1'b0;
    end else if (coin_rise) begin
      jam_cnt  <= '0;
      coin_jam <= 1'b0;
    end else if (tick_en && !coin_clean && !coin_jam) begin
      if (jam_cnt == STUCK_LAST) begin
        coin_jam <= 1'b1;
      end else begin
        jam_cnt <= jam_cnt + 12'd1;
      end
    end
  end

  // Queue bookkeeping. The replay decrement is applied first, and an
  // incoming coin is judged against what remains afterwards. A coin that
  // arrives on the same edge a queued coin leaves therefore always fits.
  assign coin_accept = coin_fall && !coin_jam;
  assign replay_take = tick_en && (state == IDLE) && (coin_pending != 2'd0);
  assign pending_dec = coin_pending - {1'b0, replay_take};

  always_comb begin
    pending_next = pending_dec;
    coin_drop    = 1'b0;
    if (coin_accept) begin
      if (pending_dec == 2'd3) begin
        coin_drop = 1'b1;
      end else begin
        pending_next = pending_dec + 2'd1;
      end
    end
  end

  // Queue register and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      coin_pending  <= 2'd0;
      coin_overflow <= 1'b0;
    end else begin
      coin_pending <= pending_next;
      if (coin_drop) begin
        coin_overflow <= 1'b1;
      end
    end
  end

  // Replay FSM. Each queued coin becomes COIN_PULSE_TICKS ticks of low
  // output followed by at least COIN_GAP_TICKS ticks of high output. The
  // timer holds ticks-remaining-minus-one, so a zero timer means this tick
  // is the last one of the phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      coin_out <= 1'b1;
    end else if (tick_en) begin
      case (state)
        IDLE: begin
          if (coin_pending != 2'd0) begin
            state    <= PULSE;
            timer    <= PULSE_LAST;
            coin_out <= 1'b0;
          end
        end
        PULSE: begin
          if (timer == 8'd0) begin
            state    <= GAP;
            timer    <= GAP_LAST;
            coin_out <= 1'b1;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        GAP: begin
          if (timer == 8'd0) begin
            state <= IDLE;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        default: begin
          state    <= IDLE;
          coin_out <= 1'b1;
        end
      endcase
    end
  end

`ifdef INPUT_COIN_COUNTER_EN
  // Lifetime count of coins that actually entered the queue. Dropped coins
  // are not counted.
  logic        coin_counted;
  logic [15:0] total_q;

  assign coin_counted = coin_accept && !coin_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      total_q <= '0;
    end else if (coin_counted) begin
      total_q <= total_q + 16'd1;
    end
  end

  assign coin_total = total_q;
`else
  assign coin_total = '0;
`endif

endmodule

// File: tb/tb_arcade_input_conditioner.sv
// tb_arcade_input_conditioner
//
// Self-checking bench for arcade_input_conditioner at default parameters.
// Stimulus is applied once per sample period, with tick_en pulsed every
// 16 clk. A tick-level reference model works from the behavioural rules:
//   - run-length debounce
//   - queue arithmetic
//   - pulse windows computed from start tick numbers
//   - jam as "low for at least STUCK ticks since the fall"

module tb_arcade_input_conditioner;

  localparam int N = 8;
  localparam int D = 4;
  localparam int P = 6;
  localparam int G = 6;
  localparam int S = 300;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick_en = 1'b0;
  logic [N-1:0]  btn_raw = '1;
  logic          coin_raw = 1'b1;
  logic [N-1:0]  btn_clean;
  logic          coin_out;
  logic [1:0]    coin_pending;
  logic          coin_overflow;
  logic          coin_jam;
  logic [15:0]   coin_total;

  int total_checks = 0;
  int bad_checks = 0;

  // Reference model state.
  int t = 0;
  bit m_clean [0:N];
  int m_run [0:N];
  int m_pending;
  bit m_ovf;
  int m_total;
  int m_fall_tick;
  int m_next_free;
  int m_pulse_start;

  arcade_input_conditioner #(
    .NUM_INPUTS(N),
    .DEBOUNCE_TICKS(D),
    .COIN_PULSE_TICKS(P),
    .COIN_GAP_TICKS(G),
    .STUCK_TICKS(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick_en(tick_en),
    .btn_raw(btn_raw),
    .coin_raw(coin_raw),
    .btn_clean(btn_clean),
    .coin_out(coin_out),
    .coin_pending(coin_pending),
    .coin_overflow(coin_overflow),
    .coin_jam(coin_jam),
    .coin_total(coin_total)
  );

  always #5 clk = ~clk;

  function automatic int mCoinOut();
    return (t >= m_pulse_start && t < m_pulse_start + P) ? 0 : 1;
  endfunction

  function automatic int mJam();
    return (!m_clean[N] && (t - m_fall_tick >= S)) ? 1 : 0;
  endfunction

  function automatic int mBtn();
    int v = 0;
    for (int i = 0; i < N; i++) v = v | (int'(m_clean[i]) << i);
    return v;
  endfunction

  function automatic int mTotal();
`ifdef INPUT_COIN_COUNTER_EN
    return m_total;
`else
    return 0;
`endif
  endfunction

  task automatic modelReset();
    for (int i = 0; i <= N; i++) begin
      m_clean[i] = 1'b1;
      m_run[i] = 0;
    end
    m_pending = 0;
    m_ovf = 1'b0;
    m_total = 0;
    m_fall_tick = t;
    m_next_free = t;
    m_pulse_start = -1000;
  endtask

  task automatic modelTick(input logic [N-1:0] b, input logic c);
    int jam_before;
    bit fell;
    bit lvl;
    jam_before = mJam();
    fell = 1'b0;
    t++;
    if (t >= m_next_free && m_pending > 0) begin
      m_pulse_start = t;
      m_next_free = t + P + G + 1;
      m_pending--;
    end
    for (int i = 0; i <= N; i++) begin
      lvl = (i < N) ? b[i] : c;
      if (lvl != m_clean[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_clean[i] = lvl;
          m_run[i] = 0;
          if (i == N && lvl == 1'b0) fell = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    if (fell) begin
      m_fall_tick = t;
      if (jam_before == 0) begin
        if (m_pending == 3) begin
          m_ovf = 1'b1;
        end else begin
          m_pending++;
          m_total = (m_total + 1) % 65536;
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total_checks++;
    if (observed != expected) begin
      bad_checks++;
      $display("[TB] FAIL %s tick=%0d observed=%0d expected=%0d", tag, t, observed, expected);
    end
  endtask

  task automatic checkAll();
    checkOutput("btn_clean", int'(btn_clean), mBtn());
    checkOutput("coin_out", int'(coin_out), mCoinOut());
    checkOutput("coin_pending", int'(coin_pending), m_pending);
    checkOutput("coin_overflow", int'(coin_overflow), int'(m_ovf));
    checkOutput("coin_jam", int'(coin_jam), mJam());
    checkOutput("coin_total", int'(coin_total), mTotal());
  endtask

  // One full sample period: drive inputs, let them settle through the
  // synchroniser, pulse tick_en for one clk, then compare with the model.
  task automatic applyStimulus(input logic [N-1:0] b, input logic c);
    btn_raw = b;
    coin_raw = c;
    repeat (15) @(posedge clk);
    #1 tick_en = 1'b1;
    @(posedge clk);
    #1 tick_en = 1'b0;
    modelTick(b, c);
    checkAll();
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    modelReset();
    checkAll();
  endtask

  initial begin
    logic [N-1:0] rb;
    logic [N-1:0] fb;
    logic rc;
    int hold;
    bit found;

    modelReset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkAll();

    // Bouncing press on button 2, then a hold and a release.
    for (int k = 0; k < 10; k++) applyStimulus(((k / 2) % 2 == 0) ? 8'hFB : 8'hFF, 1'b1);
    for (int k = 0; k < 8; k++) applyStimulus(8'hFB, 1'b1);
    for (int k = 0; k < 8; k++) applyStimulus(8'hFF, 1'b1);

    // A single clean coin.
    for (int k = 0; k < 20; k++) applyStimulus('1, 1'b0);
    for (int k = 0; k < 25; k++) applyStimulus('1, 1'b1);

    // Back-to-back coins, faster than the replay can drain the queue.
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 4; k++) applyStimulus('1, 1'b0);
      for (int k = 0; k < 4; k++) applyStimulus('1, 1'b1);
    end

    // Reset on the third low tick of a replay pulse.
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      applyStimulus('1, 1'b1);
      if (mCoinOut() == 0 && t - m_pulse_start == 2) begin
        pulseReset();
        found = 1'b1;
      end
    end
    checkOutput("rst_mid_pulse_reached", int'(found), 1);
    for (int k = 0; k < 20; k++) applyStimulus('1, 1'b1);

    // Jammed coin switch with a short bounce while jammed, then release.
    for (int k = 0; k < 320; k++) applyStimulus('1, 1'b0);
    for (int k = 0; k < 2; k++) applyStimulus('1, 1'b1);
    for (int k = 0; k < 80; k++) applyStimulus('1, 1'b0);
    for (int k = 0; k < 25; k++) applyStimulus('1, 1'b1);

    // Queue some coins, then freeze tick_en while inputs toggle wildly.
    for (int k = 0; k < 5; k++) applyStimulus(8'h5A, 1'b0);
    for (int k = 0; k < 2; k++) applyStimulus(8'h5A, 1'b1);
    for (int k = 0; k < 1000; k++) begin
      fb = N'($urandom());
      btn_raw = fb;
      coin_raw = 1'($urandom());
      @(posedge clk);
      #1;
      if (k % 10 == 9) begin
        checkOutput("freeze_btn_clean", int'(btn_clean), mBtn());
        checkOutput("freeze_coin_out", int'(coin_out), mCoinOut());
        checkOutput("freeze_coin_pending", int'(coin_pending), m_pending);
        checkOutput("freeze_coin_jam", int'(coin_jam), mJam());
      end
    end
    for (int k = 0; k < 30; k++) applyStimulus('1, 1'b1);

    // Randomised traffic: bouncy buttons, coin switch with random hold
    // lengths, and an occasional reset.
    rb = '1;
    rc = 1'b1;
    hold = 0;
    for (int k = 0; k < 600; k++) begin
      rb = rb ^ (N'($urandom()) & N'($urandom()) & N'($urandom()));
      if (hold == 0) begin
        rc = ~rc;
        hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 12);
      end
      hold--;
      applyStimulus(rb, rc);
      if ($urandom_range(0, 399) == 0) pulseReset();
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
